// File: rtl/ooo_rob_index_alloc.sv
// ---------------------------------------------------------------------------
// ooo_rob_index_alloc
//
// Reorder-buffer index allocator at the execute end of the dispatch path.
// It owns the ROB index space and hands decode the index for each dispatched
// instruction. It tracks head (oldest), tail (next free) and occupancy,
// retires entries on commit, blocks dispatch behind an in-flight halt, and
// empties on flush.
//
// Ports:
//   CLK, nRST      clock; asynchronous active-low reset
//   alloc_req      decode has a valid instruction that needs an entry
//   alloc_halt     that instruction is a halt (qualified by alloc_req)
//   alloc_gnt      allocation accepted this cycle (combinational)
//   rob_index      index for the current request (the tail pointer)
//   commit_valid   oldest entry retires this cycle
//   head_index     index of the oldest in-flight entry
//   flush          squash every in-flight entry
//   rob_full       occupancy == NUM_ROB_ENTRIES
//   rob_empty      occupancy == 0
//   halt_pending   an allocated halt has not yet retired
//   occupancy      number of in-flight entries
// ---------------------------------------------------------------------------
module ooo_rob_index_alloc #(
  parameter int NUM_ROB_ENTRIES = 16,
  parameter int ROB_IDX_W       = $clog2(NUM_ROB_ENTRIES)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 alloc_req,
  input  logic                 alloc_halt,
  output logic                 alloc_gnt,
  output logic [ROB_IDX_W-1:0] rob_index,
  input  logic                 commit_valid,
  output logic [ROB_IDX_W-1:0] head_index,
  input  logic                 flush,
  output logic                 rob_full,
  output logic                 rob_empty,
  output logic                 halt_pending,
  output logic [ROB_IDX_W:0]   occupancy
);

  localparam int CNT_W = ROB_IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_ROB_ENTRIES);
  localparam logic [ROB_IDX_W-1:0] IDX_ONE = {{(ROB_IDX_W-1){1'b0}}, 1'b1};

  logic [ROB_IDX_W-1:0] head_reg, head_next;
  logic [ROB_IDX_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic                 halt_pending_reg, halt_pending_next;
  logic [ROB_IDX_W-1:0] halt_idx_reg, halt_idx_next;

  logic alloc_fire;
  logic commit_fire;

  // Status comes from the registered count only, so a commit while full
  // cannot open a slot for an allocation in the same cycle.
  assign rob_full     = (count_reg == FULL_COUNT);
  assign rob_empty    = (count_reg == '0);
  assign occupancy    = count_reg;
  assign rob_index    = tail_reg;
  assign head_index   = head_reg;
  assign halt_pending = halt_pending_reg;

  assign alloc_gnt   = alloc_req & ~rob_full & ~halt_pending_reg & ~flush;
  assign alloc_fire  = alloc_gnt;
  // A commit against an empty ROB is meaningless and is dropped.
  assign commit_fire = commit_valid & ~rob_empty & ~flush;

  always_comb begin
    head_next         = head_reg;
    tail_next         = tail_reg;
    count_next        = count_reg;
    halt_pending_next = halt_pending_reg;
    halt_idx_next     = halt_idx_reg;

    if (flush) begin
      // Restart the index space at the oldest retained point.
      tail_next         = head_reg;
      count_next        = '0;
      halt_pending_next = 1'b0;
    end else begin
      // Power-of-two depth: pointer wrap is the natural adder overflow.
      if (alloc_fire)  tail_next = tail_reg + IDX_ONE;
      if (commit_fire) head_next = head_reg + IDX_ONE;
      count_next = count_reg + {{ROB_IDX_W{1'b0}}, alloc_fire}
                             - {{ROB_IDX_W{1'b0}}, commit_fire};
      // The halt retires when its own entry is committed.
      if (commit_fire && (head_reg == halt_idx_reg)) halt_pending_next = 1'b0;
      // Grants are blocked while a halt is pending, so a set never
      // coincides with the retirement of a live halt.
      if (alloc_fire && alloc_halt) begin
        halt_pending_next = 1'b1;
        halt_idx_next     = tail_reg;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_reg         <= '0;
      tail_reg         <= '0;
      count_reg        <= '0;
      halt_pending_reg <= 1'b0;
      halt_idx_reg     <= '0;
    end else begin
      head_reg         <= head_next;
      tail_reg         <= tail_next;
      count_reg        <= count_next;
      halt_pending_reg <= halt_pending_next;
      halt_idx_reg     <= halt_idx_next;
    end
  end

endmodule

// File: tb/tb_ooo_rob_index_alloc.sv
// ---------------------------------------------------------------------------
// tb_ooo_rob_index_alloc
//
// Directed scoreboard bench. The stimulus process drives one vector per
// cycle shortly after the rising edge and queues the outputs it expects to
// see during that cycle; the monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_ooo_rob_index_alloc;

  logic       CLK;
  logic       nRST;
  logic       alloc_req;
  logic       alloc_halt;
  logic       alloc_gnt;
  logic [3:0] rob_index;
  logic       commit_valid;
  logic [3:0] head_index;
  logic       flush;
  logic       rob_full;
  logic       rob_empty;
  logic       halt_pending;
  logic [4:0] occupancy;

  ooo_rob_index_alloc #(.NUM_ROB_ENTRIES(16)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .alloc_req    (alloc_req),
    .alloc_halt   (alloc_halt),
    .alloc_gnt    (alloc_gnt),
    .rob_index    (rob_index),
    .commit_valid (commit_valid),
    .head_index   (head_index),
    .flush        (flush),
    .rob_full     (rob_full),
    .rob_empty    (rob_empty),
    .halt_pending (halt_pending),
    .occupancy    (occupancy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic       gnt;
    logic [3:0] idx;
    logic [3:0] head;
    logic [4:0] occ;
    logic       full;
    logic       empty;
    logic       hp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  task automatic check_field(input string tname, input string fname,
                             input logic [4:0] act, input logic [4:0] exp,
                             inout int errs);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      errs++;
      $display("FAIL %s.%s: got %0d, expected %0d", tname, fname, act, exp);
    end
  endtask

  // Monitor: compare whatever the stimulus queued for this cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int   errs;
      e    = exp_q.pop_front();
      errs = 0;
      check_field(e.name, "alloc_gnt",    {4'd0, alloc_gnt},    {4'd0, e.gnt},   errs);
      check_field(e.name, "rob_index",    {1'b0, rob_index},    {1'b0, e.idx},   errs);
      check_field(e.name, "head_index",   {1'b0, head_index},   {1'b0, e.head},  errs);
      check_field(e.name, "occupancy",    occupancy,            e.occ,           errs);
      check_field(e.name, "rob_full",     {4'd0, rob_full},     {4'd0, e.full},  errs);
      check_field(e.name, "rob_empty",    {4'd0, rob_empty},    {4'd0, e.empty}, errs);
      check_field(e.name, "halt_pending", {4'd0, halt_pending}, {4'd0, e.hp},    errs);
      $display("txn %0d %s: gnt=%0b idx=%0d head=%0d occ=%0d full=%0b empty=%0b hp=%0b errors=%0d",
               n_txn, e.name, alloc_gnt, rob_index, head_index, occupancy,
               rob_full, rob_empty, halt_pending, errs);
      n_txn++;
    end
  end

  // One cycle of stimulus plus its expected outputs. drop_rst pulls nRST
  // low a little after the inputs settle, well before the next clock edge.
  task automatic step(input string name, input logic req, input logic halt,
                      input logic cv, input logic fl,
                      input logic e_gnt, input int e_idx, input int e_head,
                      input int e_occ, input logic e_full, input logic e_empty,
                      input logic e_hp, input logic drop_rst = 1'b0);
    exp_t e;
    @(posedge CLK);
    #1;
    alloc_req    = req;
    alloc_halt   = halt;
    commit_valid = cv;
    flush        = fl;
    e.name  = name;
    e.gnt   = e_gnt;
    e.idx   = 4'(e_idx);
    e.head  = 4'(e_head);
    e.occ   = 5'(e_occ);
    e.full  = e_full;
    e.empty = e_empty;
    e.hp    = e_hp;
    exp_q.push_back(e);
    if (drop_rst) begin
      #2;
      nRST = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    #1;
    alloc_req = 0; alloc_halt = 0; commit_valid = 0; flush = 0;
    nRST = 1'b0;
    @(negedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0; alloc_req = 0; alloc_halt = 0; commit_valid = 0; flush = 0;

    // Reset values while nRST is held low.
    step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    release_reset();

    // Fill: 16 grants with indices 0..15, then refused when full.
    for (int i = 0; i < 16; i++)
      step($sformatf("fill%0d", i), 1, 0, 0, 0, 1, i, 0, i, 0, (i == 0), 0);
    step("full_refuse", 1, 0, 0, 0, 0, 0, 0, 16, 1, 0, 0);

    // Full: commit with request does not grant; next cycle grants index 0.
    step("full_commit", 1, 0, 1, 0, 0, 0, 0, 16, 1, 0, 0);
    step("after_commit", 1, 0, 0, 0, 1, 0, 1, 15, 0, 0, 0);
    step("refull", 0, 0, 0, 0, 0, 1, 1, 16, 1, 0, 0);

    // Empty: a lone commit is ignored; alloc+commit at occupancy 3.
    pulse_reset();
    step("empty_commit", 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    step("empty_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("a0", 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    step("a1", 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    step("a2", 1, 0, 0, 0, 1, 2, 0, 2, 0, 0, 0);
    step("alloc_commit", 1, 0, 1, 0, 1, 3, 0, 3, 0, 0, 0);
    step("after_ac", 0, 0, 0, 0, 0, 4, 1, 3, 0, 0, 0);

    // Halt at index 2 blocks grants until it retires.
    pulse_reset();
    step("h0", 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    step("h1", 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    step("halt_alloc", 1, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0);
    step("halt_block", 1, 0, 0, 0, 0, 3, 0, 3, 0, 0, 1);
    step("halt_c0", 1, 0, 1, 0, 0, 3, 0, 3, 0, 0, 1);
    step("halt_c1", 1, 0, 1, 0, 0, 3, 1, 2, 0, 0, 1);
    step("halt_c2", 1, 0, 1, 0, 0, 3, 2, 1, 0, 0, 1);
    step("halt_done", 1, 0, 0, 0, 1, 3, 3, 0, 0, 1, 0);

    // Flush at head=4, tail=9, with a halt in flight at index 8.
    pulse_reset();
    for (int i = 0; i < 9; i++)
      step($sformatf("f_alloc%0d", i), 1, (i == 8), 0, 0, 1, i, 0, i, 0, (i == 0), 0);
    for (int j = 0; j < 4; j++)
      step($sformatf("f_commit%0d", j), 0, 0, 1, 0, 0, 9, j, 9 - j, 0, 0, 1);
    step("flush", 1, 0, 1, 1, 0, 9, 4, 5, 0, 0, 1);
    step("after_flush", 0, 0, 0, 0, 0, 4, 4, 0, 0, 1, 0);

    // Async reset mid-cycle at occupancy 7.
    for (int i = 0; i < 7; i++)
      step($sformatf("r_alloc%0d", i), 1, 0, 0, 0, 1, 4 + i, 4, i, 0, (i == 0), 0);
    step("occ7", 0, 0, 0, 0, 0, 11, 4, 7, 0, 0, 0);
    step("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1'b1);
    release_reset();

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ooo_rob_index_alloc.md
Name: ooo_rob_index_alloc

Overview:
- Execute-end responder to the decode→execute dispatch path.
- Owns the reorder-buffer index space and returns the rob_index that decode attaches to each dispatched instruction.
- Tracks head (oldest) and tail (next free) pointers and occupancy, and grants or refuses allocation.
- Retires entries on commit, blocks dispatch behind a pending halt, and empties on flush.

Parameters:
- NUM_ROB_ENTRIES, 16, number of ROB entries; must be a power of two and ≥2.
- ROB_IDX_W, $clog2(NUM_ROB_ENTRIES), width of rob_index.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- alloc_req  in  1  decode holds a valid, non-stalled instruction that needs an entry.
- alloc_halt  in  1  the requesting instruction is a halt (qualified by alloc_req).
- alloc_gnt  out  1  allocation accepted this cycle.
- rob_index  out  ROB_IDX_W  index assigned to the current request; equals the tail register.
- commit_valid  in  1  the ROB retires its oldest entry this cycle.
- head_index  out  ROB_IDX_W  index of the oldest in-flight entry.
- flush  in  1  squash all in-flight entries.
- rob_full  out  1  count == NUM_ROB_ENTRIES.
- rob_empty  out  1  count == 0.
- halt_pending  out  1  an allocated halt has not yet retired.
- occupancy  out  ROB_IDX_W+1  current count.

Behaviour:
- State registers: head, tail (ROB_IDX_W each), count (ROB_IDX_W+1), halt_pending, halt_idx.
- Reset (async, nRST=0): head=0, tail=0, count=0, halt_pending=0, halt_idx=0.
  - Resulting outputs: rob_index=0, head_index=0, rob_full=0, rob_empty=1, occupancy=0, alloc_gnt=0.
  - Reset asserted mid-operation discards all state immediately, with no completion of the current cycle.
- Combinational outputs:
  - rob_full, rob_empty and occupancy derive from the registered count only.
  - alloc_gnt = alloc_req & ~rob_full & ~halt_pending & ~flush. Zero-cycle latency, same cycle as the request.
- Handshake: decode may change alloc_req/alloc_halt every cycle. An instruction is dispatched only in a cycle where alloc_gnt=1, and it must capture rob_index in that same cycle.
- Allocation and commit qualifiers:
  - alloc_fire = alloc_gnt.
  - commit_fire = commit_valid & ~rob_empty & ~flush. commit_valid while empty is ignored, with no pointer or count change.
- Next-state, priority order:
  - flush: tail←head, count←0, halt_pending←0. head is unchanged; the index space restarts at the oldest retained point.
  - Otherwise:
    - alloc_fire: tail←tail+1, wrapping modulo NUM_ROB_ENTRIES (NUM_ROB_ENTRIES-1 → 0).
    - commit_fire: head←head+1, with the same wrap.
    - count←count + alloc_fire − commit_fire. Simultaneous alloc and commit leaves count unchanged.
- Full boundary: when full, a commit in the same cycle does NOT enable allocation that cycle, because rob_full is registered. The grant occurs no earlier than the following cycle.
- Empty boundary: when empty, allocation and a (discarded) commit in the same cycle give count=1.
- Halt handling:
  - alloc_fire & alloc_halt sets halt_pending←1 and halt_idx←tail.
  - While halt_pending=1, no further grants are issued.
  - halt_pending clears on a commit_fire with head==halt_idx, or on flush.
- Invariant: count ≤ NUM_ROB_ENTRIES. tail−head (mod N) equals count, except that head==tail holds both when full and when empty; count disambiguates the two.

Test Plan:
- Reset → rob_index=0, head_index=0, rob_empty=1, rob_full=0, occupancy=0. Release nRST; alloc_req=1 for 16 cycles → alloc_gnt=1 with rob_index 0..15; rob_full=1 after the 16th grant; 17th request → alloc_gnt=0.
- When full, commit_valid=1 and alloc_req=1 in the same cycle → alloc_gnt=0, head_index 0→1, occupancy=15. Next cycle → alloc_gnt=1, rob_index=0 (wrap), occupancy=16.
- Empty ROB, commit_valid=1 alone → no change (head_index=0, occupancy=0). Alloc and commit together with occupancy=3 → occupancy stays 3, both pointers advance.
- Allocate a halt at index 2 (entries 0,1 in flight) → halt_pending=1, alloc_gnt=0 on subsequent requests. Commit three entries → halt_pending clears on the commit with head==2; the next request is granted index 3.
- Occupancy 5 with head=4, tail=9; assert flush together with alloc_req and commit_valid → alloc_gnt=0; next cycle tail=4, head=4, occupancy=0, rob_empty=1, halt_pending=0.
- Drop nRST asynchronously mid-cycle at occupancy 7 → all outputs return to reset values immediately, without waiting for a clock edge.
